// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite blitter and its output stage.
package sprite_pkg;

  localparam int SPR_W    = 126;
  localparam int SPR_H    = 60;
  localparam int ADDR_W   = 13;
  localparam int PIX_W    = 4;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int NUM_PIX  = SPR_W * SPR_H;
  localparam int COL_W    = 7;
  localparam int ROW_W    = 6;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t TRANSP = 4'h0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } blit_state_t;

endpackage

// File: rtl/sprite_blitter_out_stage.sv
// Stage B: pairs the issued-address tag with ROM data, clips/keys the pixel and
// holds it in the frame-buffer output register, parking one in-flight word in a skid.
module blit_out_stage
  import sprite_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  input  logic [COL_W-1:0] in_col,
  input  logic [ROW_W-1:0] in_row,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic [PIX_W-1:0] spr_data,
  input  logic             fb_ready,
  output logic             fb_we,
  output logic [9:0]       fb_x,
  output logic [9:0]       fb_y,
  output logic [PIX_W-1:0] fb_data,
  output logic             stall,
  output logic             skid_full
);

  logic             fb_we_q, fb_we_d;
  logic [9:0]       fb_x_q, fb_x_d;
  logic [9:0]       fb_y_q, fb_y_d;
  logic [PIX_W-1:0] fb_data_q, fb_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [9:0]       skid_x_q, skid_x_d;
  logic [9:0]       skid_y_q, skid_y_d;
  logic [PIX_W-1:0] skid_data_q, skid_data_d;

  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic        in_vis;

  // 11-bit sums so positions past 1023 clip instead of wrapping onto the screen
  assign x_sum  = {1'b0, pos_x} + 11'(in_col);
  assign y_sum  = {1'b0, pos_y} + 11'(in_row);
  assign in_vis = in_valid && (spr_data != TRANSP) &&
                  (x_sum < 11'(SCREEN_W)) && (y_sum < 11'(SCREEN_H));

  assign stall = fb_we_q && !fb_ready;

  always_comb begin
    fb_we_d      = fb_we_q;
    fb_x_d       = fb_x_q;
    fb_y_d       = fb_y_q;
    fb_data_d    = fb_data_q;
    skid_valid_d = skid_valid_q;
    skid_x_d     = skid_x_q;
    skid_y_d     = skid_y_q;
    skid_data_d  = skid_data_q;
    if (stall) begin
      if (in_vis) begin
        skid_valid_d = 1'b1;
        skid_x_d     = x_sum[9:0];
        skid_y_d     = y_sum[9:0];
        skid_data_d  = spr_data;
      end
    end else if (skid_valid_q) begin
      fb_we_d      = 1'b1;
      fb_x_d       = skid_x_q;
      fb_y_d       = skid_y_q;
      fb_data_d    = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (in_vis) begin
      fb_we_d   = 1'b1;
      fb_x_d    = x_sum[9:0];
      fb_y_d    = y_sum[9:0];
      fb_data_d = spr_data;
    end else begin
      fb_we_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fb_we_q      <= 1'b0;
      fb_x_q       <= '0;
      fb_y_q       <= '0;
      fb_data_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_x_q     <= '0;
      skid_y_q     <= '0;
      skid_data_q  <= '0;
    end else begin
      fb_we_q      <= fb_we_d;
      fb_x_q       <= fb_x_d;
      fb_y_q       <= fb_y_d;
      fb_data_q    <= fb_data_d;
      skid_valid_q <= skid_valid_d;
      skid_x_q     <= skid_x_d;
      skid_y_q     <= skid_y_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign fb_we     = fb_we_q;
  assign fb_x      = fb_x_q;
  assign fb_y      = fb_y_q;
  assign fb_data   = fb_data_q;
  assign skid_full = skid_valid_q;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: FSM plus raster address/col/row counters feeding a
// 1-cycle-latency sprite ROM; pixel handling lives in blit_out_stage.
module sprite_blitter
  import sprite_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] spr_addr,
  input  logic [PIX_W-1:0]  spr_data,
  output logic              fb_we,
  output logic [9:0]        fb_x,
  output logic [9:0]        fb_y,
  output logic [PIX_W-1:0]  fb_data,
  input  logic              fb_ready
);

  blit_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic              a_valid_q, a_valid_d;
  logic [COL_W-1:0]  a_col_q, a_col_d;
  logic [ROW_W-1:0]  a_row_q, a_row_d;

  logic out_stall;
  logic skid_full;
  logic issue;
  logic last_addr;
  logic drain_done;

  assign issue      = (state_q == FETCH) && !out_stall;
  assign last_addr  = (addr_q == ADDR_W'(NUM_PIX - 1));
  assign drain_done = !a_valid_q && !skid_full && !out_stall;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      a_valid_q <= 1'b0;
      a_col_q   <= '0;
      a_row_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      a_valid_q <= a_valid_d;
      a_col_q   <= a_col_d;
      a_row_q   <= a_row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (issue && last_addr) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // col/row shadow the linear address so no multiplier is needed for the tag
  always_comb begin
    addr_d    = addr_q;
    col_d     = col_q;
    row_d     = row_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    a_valid_d = issue;
    a_col_d   = col_q;
    a_row_d   = row_q;
    if ((state_q == IDLE) && start) begin
      pos_x_d = pos_x;
      pos_y_d = pos_y;
      addr_d  = '0;
      col_d   = '0;
      row_d   = '0;
    end else if (issue && !last_addr) begin
      addr_d = addr_q + 1'b1;
      if (col_q == COL_W'(SPR_W - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DRAIN) && drain_done;
    spr_addr = addr_q;
  end

  blit_out_stage u_out (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (a_valid_q),
    .in_col    (a_col_q),
    .in_row    (a_row_q),
    .pos_x     (pos_x_q),
    .pos_y     (pos_y_q),
    .spr_data  (spr_data),
    .fb_ready  (fb_ready),
    .fb_we     (fb_we),
    .fb_x      (fb_x),
    .fb_y      (fb_y),
    .fb_data   (fb_data),
    .stall     (out_stall),
    .skid_full (skid_full)
  );

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: registered ROM model, write scoreboard
// with stall-stability tracking, and a linear sequence of blit scenarios.
module tb_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        busy;
  logic        done;
  logic [12:0] spr_addr;
  logic [3:0]  spr_data;
  logic        fb_we;
  logic [9:0]  fb_x;
  logic [9:0]  fb_y;
  logic [3:0]  fb_data;
  logic        fb_ready;

  int tests = 0;
  int failures = 0;

  int mpx = 0;
  int mpy = 0;
  bit rom_zero = 1'b0;
  bit rand_ready = 1'b0;
  bit fixed_ready = 1'b1;
  bit sb_clear = 1'b0;

  int wr_count = 0;
  int exp_k = 0;
  int seq_err = 0;
  int stab_err = 0;
  int clip_err = 0;
  int done_count = 0;
  bit prev_stall = 1'b0;
  logic [9:0] prev_x;
  logic [9:0] prev_y;
  logic [3:0] prev_data;

  sprite_blitter dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .busy     (busy),
    .done     (done),
    .spr_addr (spr_addr),
    .spr_data (spr_data),
    .fb_we    (fb_we),
    .fb_x     (fb_x),
    .fb_y     (fb_y),
    .fb_data  (fb_data),
    .fb_ready (fb_ready)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    spr_data <= rom_zero ? 4'h0 : 4'((int'(spr_addr) % 15) + 1);
  end

  function automatic bit vis(input int k);
    int x, y, d;
    x = mpx + k % 126;
    y = mpy + k / 126;
    d = rom_zero ? 0 : (k % 15) + 1;
    return (d != 0) && (x < 640) && (y < 480);
  endfunction

  // Scoreboard: every handshake must be the next visible pixel in raster order
  always @(negedge Clk) begin
    int k;
    if (sb_clear) begin
      wr_count   <= 0;
      exp_k      <= 0;
      seq_err    <= 0;
      stab_err   <= 0;
      clip_err   <= 0;
      done_count <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (fb_we !== 1'b1 || fb_x !== prev_x || fb_y !== prev_y || fb_data !== prev_data))
        stab_err <= stab_err + 1;
      if (fb_we === 1'b1 && fb_ready === 1'b1) begin
        wr_count <= wr_count + 1;
        if (fb_x >= 10'd640 || fb_y >= 10'd480) clip_err <= clip_err + 1;
        k = exp_k;
        while (k < 7560 && !vis(k)) k++;
        if (k >= 7560) begin
          seq_err <= seq_err + 1;
        end else begin
          if (int'(fb_x) != mpx + k % 126 || int'(fb_y) != mpy + k / 126 ||
              int'(fb_data) != (k % 15) + 1)
            seq_err <= seq_err + 1;
          k++;
        end
        exp_k <= k;
      end
      if (done === 1'b1) done_count <= done_count + 1;
      prev_stall <= (fb_we === 1'b1) && (fb_ready === 1'b0);
      prev_x     <= fb_x;
      prev_y     <= fb_y;
      prev_data  <= fb_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    start = 1'b0;
    fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    @(negedge Clk);
  endtask

  task automatic clear_sb();
    @(posedge Clk);
    #1 sb_clear = 1'b1;
    @(posedge Clk);
    #1 sb_clear = 1'b0;
    @(negedge Clk);
  endtask

  task automatic launch(input int px, input int py);
    pos_x = 10'(px);
    pos_y = 10'(py);
    start = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget, output bit found, output int cycles);
    found = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      tick();
      cycles++;
      if (done === 1'b1) found = 1'b1;
    end
  endtask

  task automatic finish_blit(input string tag, input int budget, input int exp_writes);
    bit found;
    int cycles;
    wait_done(budget, found, cycles);
    check({tag, "_done_seen"}, 32'(found), 32'd1);
    tick();
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    tick();
    tick();
    check({tag, "_writes"}, 32'(wr_count), 32'(exp_writes));
    check({tag, "_order"}, 32'(seq_err), 32'd0);
    check({tag, "_done_count"}, 32'(done_count), 32'd1);
  endtask

  initial begin
    bit found;
    int cycles;
    int n;

    Reset_n  = 1'b0;
    start    = 1'b0;
    pos_x    = '0;
    pos_y    = '0;
    fb_ready = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(spr_addr), 32'd0);
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_x", 32'(fb_x), 32'd0);
    check("rst_y", 32'(fb_y), 32'd0);
    check("rst_data", 32'(fb_data), 32'd0);
    Reset_n = 1'b1;
    tick();

    // Opaque sprite at origin, always ready: latency, throughput and done timing
    $display("[TB] opaque blit at (0,0)");
    mpx = 0; mpy = 0; rom_zero = 1'b0;
    clear_sb();
    launch(0, 0);
    check("c1_busy", 32'(busy), 32'd1);
    check("c1_addr", 32'(spr_addr), 32'd0);
    check("c1_we", 32'(fb_we), 32'd0);
    tick();
    check("c2_addr", 32'(spr_addr), 32'd1);
    check("c2_we", 32'(fb_we), 32'd0);
    tick();
    check("c3_we", 32'(fb_we), 32'd1);
    check("c3_x", 32'(fb_x), 32'd0);
    check("c3_data", 32'(fb_data), 32'd1);
    tick();
    check("c4_x", 32'(fb_x), 32'd1);
    check("c4_data", 32'(fb_data), 32'd2);
    wait_done(9000, found, cycles);
    check("full_done_seen", 32'(found), 32'd1);
    check("full_done_cycle", 32'(cycles + 3), 32'd7561);
    tick();
    check("full_done_width", 32'(done), 32'd0);
    check("full_busy_after", 32'(busy), 32'd0);
    tick();
    tick();
    check("full_writes", 32'(wr_count), 32'd7560);
    check("full_order", 32'(seq_err), 32'd0);
    check("full_done_count", 32'(done_count), 32'd1);

    $display("[TB] transparent sprite");
    rom_zero = 1'b1;
    clear_sb();
    launch(0, 0);
    finish_blit("transp", 9000, 0);

    $display("[TB] clipped blit at (600,450)");
    rom_zero = 1'b0; mpx = 600; mpy = 450;
    clear_sb();
    launch(600, 450);
    finish_blit("clip", 9000, 1200);
    check("clip_bounds", 32'(clip_err), 32'd0);

    $display("[TB] random frame-buffer backpressure");
    mpx = 0; mpy = 0;
    clear_sb();
    rand_ready = 1'b1;
    launch(0, 0);
    finish_blit("rand", 40000, 7560);
    check("rand_stable", 32'(stab_err), 32'd0);
    rand_ready = 1'b0;
    fixed_ready = 1'b1;
    tick();

    $display("[TB] start while busy, then reset mid-blit");
    clear_sb();
    launch(0, 0);
    n = 0;
    while (wr_count < 1000 && n < 5000) begin tick(); n++; end
    check("reach_1000", 32'(wr_count >= 1000), 32'd1);
    pos_x = 10'd300;
    pos_y = 10'd200;
    start = 1'b1;
    tick();
    check("ignored_start_busy", 32'(busy), 32'd1);
    n = 0;
    while (wr_count < 3000 && n < 5000) begin tick(); n++; end
    check("reach_3000", 32'(wr_count >= 3000), 32'd1);
    check("ignored_start_order", 32'(seq_err), 32'd0);
    Reset_n = 1'b0;
    #1;
    check("midrst_we", 32'(fb_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", 32'(spr_addr), 32'd0);
    tick();
    tick();
    check("midrst_no_done", 32'(done_count), 32'd0);
    Reset_n = 1'b1;
    clear_sb();
    repeat (20) tick();
    check("post_rst_writes", 32'(wr_count), 32'd0);
    check("post_rst_done", 32'(done_count), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("[TB] restart after reset with a 20-cycle stall");
    launch(0, 0);
    check("restart_addr", 32'(spr_addr), 32'd0);
    tick();
    tick();
    check("restart_first_we", 32'(fb_we), 32'd1);
    fixed_ready = 1'b0;
    tick();
    check("stall_addr_start", 32'(spr_addr), 32'd3);
    check("stall_x_start", 32'(fb_x), 32'd1);
    repeat (19) tick();
    check("stall_addr_frozen", 32'(spr_addr), 32'd3);
    check("stall_x_held", 32'(fb_x), 32'd1);
    check("stall_we_held", 32'(fb_we), 32'd1);
    fixed_ready = 1'b1;
    finish_blit("stall", 9000, 7560);
    check("stall_stable", 32'(stab_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
